// File: rtl/uart_program_loader_pkg.sv
// rtl/uart_program_loader_pkg.sv - shared loader state encoding, timeout default and image byte order
package uart_program_loader_pkg;

  typedef enum logic [2:0] {
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

  localparam int TIMEOUT_DEFAULT = 100000;

  // Image words travel big-endian: the first byte on the wire is the high byte.
  function automatic logic [15:0] image_word(input logic [7:0] first, input logic [7:0] second);
    return {first, second};
  endfunction

  // States that wait on a byte from an image that has already started.
  function automatic logic timed_state(input loader_state_t s);
    return (s == ST_CNT_LO) || (s == ST_DATA_HI) || (s == ST_DATA_LO) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - idle-cycle counter that flags the cycle on which LIMIT would be reached
module loader_timeout #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Expiry is combinational so the caller can act on the same cycle the limit is hit.
  assign expired = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - boot sequencer: loads a UART program image into RAM, verifies it, releases the CPU
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              cpu_ram_re,
  input  logic              cpu_ram_we,
  input  logic [ADDR_W-1:0] cpu_ram_addr,
  input  logic [DATA_W-1:0] cpu_ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  loader_state_t   state, state_next;
  logic [15:0]     count;
  logic [7:0]      hi_byte, lo_byte, chk;
  logic [ADDR_W:0] idx;
  logic            hold_q, done_q, error_q;
  logic            tmo_enable, tmo_expired;
  logic [15:0]     n_rx;
  logic            last_word;

  assign n_rx       = {count[15:8], rx_data};
  assign last_word  = (17'(idx) + 17'd1) == 17'(count);
  assign tmo_enable = timed_state(state) && !rx_valid;

  loader_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!tmo_enable),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CNT_HI;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CNT_HI: begin
        if (rx_valid) state_next = ST_CNT_LO;
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          if (17'(n_rx) > MAX_WORDS) state_next = ST_ERROR;
          else if (n_rx == 16'd0)    state_next = ST_CHECK;
          else                       state_next = ST_DATA_HI;
        end else if (tmo_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_DATA_HI: begin
        if (rx_valid)         state_next = ST_DATA_LO;
        else if (tmo_expired) state_next = ST_ERROR;
      end
      ST_DATA_LO: begin
        if (rx_valid)         state_next = ST_WRITE;
        else if (tmo_expired) state_next = ST_ERROR;
      end
      ST_WRITE: begin
        // A byte arriving while the word is being committed means the sender overran us.
        if (rx_valid)       state_next = ST_ERROR;
        else if (last_word) state_next = ST_CHECK;
        else                state_next = ST_DATA_HI;
      end
      ST_CHECK: begin
        if (rx_valid)         state_next = (rx_data == chk) ? ST_RUN : ST_ERROR;
        else if (tmo_expired) state_next = ST_ERROR;
      end
      ST_RUN:   state_next = ST_RUN;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      hi_byte <= '0;
      lo_byte <= '0;
      chk     <= '0;
      idx     <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      hold_q  <= (state_next != ST_RUN);
      done_q  <= (state_next == ST_RUN);
      error_q <= (state_next == ST_ERROR);
      case (state)
        ST_CNT_HI:  if (rx_valid) count[15:8] <= rx_data;
        ST_CNT_LO:  if (rx_valid) count[7:0] <= rx_data;
        ST_DATA_HI: begin
          if (rx_valid) begin
            hi_byte <= rx_data;
            chk     <= chk ^ rx_data;
          end
        end
        ST_DATA_LO: begin
          if (rx_valid) begin
            lo_byte <= rx_data;
            chk     <= chk ^ rx_data;
          end
        end
        ST_WRITE:   idx <= idx + 1'b1;
        default:    ;
      endcase
    end
  end

  // The CPU only ever sees the RAM once the image has been verified.
  always_comb begin
    ram_re    = 1'b0;
    ram_we    = (state == ST_WRITE);
    ram_addr  = idx[ADDR_W-1:0];
    ram_wdata = DATA_W'(image_word(hi_byte, lo_byte));
    if (state == ST_RUN) begin
      ram_re    = cpu_ram_re;
      ram_we    = cpu_ram_we;
      ram_addr  = cpu_ram_addr;
      ram_wdata = cpu_ram_wdata;
    end
  end

  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign load_count = idx;

endmodule
